// File: rtl/mem_access_if.sv
// Bus bundle between execute, the memory-access stage, write-back and the data memory.
// The slave modport is the stage's view of it; the master modport is the surrounding core's.
interface mem_access_if #(
  parameter int MEM_AW = 18
);
  logic              enable;
  logic              done;
  logic              memread;
  logic              memwrite;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       store_data;
  logic [2:0]        wselector_in;
  logic              wfrommem_in;
  logic [31:0]       pc_in;
  logic [31:0]       data_in;
  logic [4:0]        rd_in;
  logic [2:0]        wselector;
  logic              wfrommem;
  logic [31:0]       pc;
  logic [31:0]       data;
  logic [4:0]        rd;
  logic [31:0]       data_mem;
  logic              misaligned;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport slave (
    input  enable, memread, memwrite, funct3, addr, store_data,
           wselector_in, wfrommem_in, pc_in, data_in, rd_in,
           mem_ready, mem_rdata,
    output done, wselector, wfrommem, pc, data, rd, data_mem, misaligned,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output enable, memread, memwrite, funct3, addr, store_data,
           wselector_in, wfrommem_in, pc_in, data_in, rd_in,
           mem_ready, mem_rdata,
    input  done, wselector, wfrommem, pc, data, rd, data_mem, misaligned,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: byte/half/word loads and stores over a req/ready handshake,
// then a one-cycle done with the extended load result and registered write-back fields.
module mem_access #(
  parameter int MEM_AW = 18
) (
  input logic         clk,
  input logic         rst,
  mem_access_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, FIN = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              skip_q, load_q, we_q, misaligned_q;
  logic [2:0]        funct3_q;
  logic [1:0]        off_q;
  logic [2:0]        wselector_q;
  logic              wfrommem_q;
  logic [31:0]       pc_q, data_q, data_mem_q;
  logic [4:0]        rd_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_wstrb_q;

  logic              accept, is_mem, mis_c;
  logic [31:0]       wdata_c, load_c;
  logic [3:0]        wstrb_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;

  assign accept = (state_q == IDLE) && bus.enable;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    is_mem  = bus.memread | bus.memwrite;
    mis_c   = 1'b0;
    wdata_c = bus.store_data;
    wstrb_c = 4'b1111;
    case (bus.funct3[1:0])
      2'b00: begin
        wdata_c = {4{bus.store_data[7:0]}};
        wstrb_c = 4'b0001 << bus.addr[1:0];
      end
      2'b01: begin
        mis_c   = bus.addr[0];
        wdata_c = {2{bus.store_data[15:0]}};
        wstrb_c = bus.addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10:   mis_c = |bus.addr[1:0];
      default: mis_c = 1'b1;
    endcase
    if (!is_mem)       mis_c   = 1'b0;
    if (!bus.memwrite) wstrb_c = 4'b0000;
  end

  always_comb begin
    byte_c = bus.mem_rdata[{off_q, 3'b000} +: 8];
    half_c = bus.mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q[1:0])
      2'b00:   load_c = {{24{~funct3_q[2] & byte_c[7]}}, byte_c};
      2'b01:   load_c = {{16{~funct3_q[2] & half_c[15]}}, half_c};
      default: load_c = bus.mem_rdata;
    endcase
  end

  // Faulted and non-memory ops spend their ACCESS cycle with no request, so every op
  // reaches done 2 + wait cycles after enable.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable) state_d = ACCESS;
      ACCESS:  if (skip_q || bus.mem_ready) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      skip_q       <= 1'b0;
      load_q       <= 1'b0;
      we_q         <= 1'b0;
      misaligned_q <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
      wselector_q  <= '0;
      wfrommem_q   <= 1'b0;
      pc_q         <= '0;
      data_q       <= '0;
      rd_q         <= '0;
      data_mem_q   <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        skip_q       <= !is_mem || mis_c;
        load_q       <= bus.memread;
        we_q         <= bus.memwrite;
        misaligned_q <= mis_c;
        funct3_q     <= bus.funct3;
        off_q        <= bus.addr[1:0];
        wselector_q  <= bus.wselector_in;
        wfrommem_q   <= bus.wfrommem_in;
        pc_q         <= bus.pc_in;
        data_q       <= bus.data_in;
        rd_q         <= bus.rd_in;
        data_mem_q   <= '0;
        if (is_mem && !mis_c) begin
          mem_addr_q  <= bus.addr[MEM_AW+1:2];
          mem_wdata_q <= wdata_c;
          mem_wstrb_q <= wstrb_c;
        end
      end else if (state_q == ACCESS && !skip_q && bus.mem_ready && load_q) begin
        data_mem_q <= load_c;
      end
    end
  end

  assign bus.done       = (state_q == FIN);
  assign bus.mem_req    = (state_q == ACCESS) && !skip_q;
  assign bus.mem_we     = bus.mem_req && we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.data_mem   = data_mem_q;
  assign bus.misaligned = misaligned_q;
  assign bus.wselector  = wselector_q;
  assign bus.wfrommem   = wfrommem_q;
  assign bus.pc         = pc_q;
  assign bus.data       = data_q;
  assign bus.rd         = rd_q;

endmodule
